// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
// alu_pipe_if : request/result handshake bundle for alu_pipe.
// Revision    : 1.0
// ============================================================================
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       FS;
  logic [SHW-1:0]   SH;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] F;
  logic             Z;
  logic             V;
  logic             N;
  logic             C;
  logic             ILL;
  logic             busy;

  modport master (
    output in_valid, A, B, FS, SH, out_ready,
    input  in_ready, out_valid, F, Z, V, N, C, ILL, busy
  );

  modport slave (
    input  in_valid, A, B, FS, SH, out_ready,
    output in_ready, out_valid, F, Z, V, N, C, ILL, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// alu_pipe : handshaked ALU, registered result/flags; iterative multiplier
//            built only when ALU_MUL_EN is defined.
// Revision : 1.0
// ============================================================================
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input wire logic  clk,
  input wire logic  rst,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] c_fs_pass = 5'b00000;
  localparam logic [4:0] c_fs_add  = 5'b00010;
  localparam logic [4:0] c_fs_sub  = 5'b00101;
  localparam logic [4:0] c_fs_and  = 5'b01000;
  localparam logic [4:0] c_fs_or   = 5'b01010;
  localparam logic [4:0] c_fs_xor  = 5'b01100;
  localparam logic [4:0] c_fs_not  = 5'b01110;
  localparam logic [4:0] c_fs_lsl  = 5'b10000;
  localparam logic [4:0] c_fs_lsr  = 5'b10001;
  localparam logic [4:0] c_fs_asr  = 5'b10010;
  localparam logic [4:0] c_fs_ror  = 5'b10011;

  logic [WIDTH-1:0] f_q;
  logic             z_q, v_q, n_q, c_q, ill_q, out_valid_q;

  logic             w_out_free;
  logic             w_in_ready;
  logic             w_busy;
  logic             w_load;
  logic [WIDTH-1:0] w_res_f;
  logic             w_res_c, w_res_v, w_res_ill;

  logic [WIDTH-1:0] w_sc_f;
  logic             w_sc_c, w_sc_v, w_sc_ill;
  logic [WIDTH:0]   w_sum, w_diff;
  logic             w_a_msb, w_b_msb;

  assign w_out_free = !out_valid_q || bus.out_ready;
  assign w_sum      = {1'b0, bus.A} + {1'b0, bus.B};
  assign w_diff     = {1'b0, bus.A} - {1'b0, bus.B};
  assign w_a_msb    = bus.A[WIDTH-1];
  assign w_b_msb    = bus.B[WIDTH-1];

  // Single-cycle result computed straight from the request; captured on transfer.
  always_comb begin
    w_sc_f   = '0;
    w_sc_c   = 1'b0;
    w_sc_v   = 1'b0;
    w_sc_ill = 1'b0;
    case (bus.FS)
      c_fs_pass: w_sc_f = bus.A;
      c_fs_add: begin
        {w_sc_c, w_sc_f} = w_sum;
        w_sc_v = (!w_a_msb && !w_b_msb && w_sum[WIDTH-1]) ||
                 (w_a_msb && w_b_msb && !w_sum[WIDTH-1]);
      end
      c_fs_sub: begin
        {w_sc_c, w_sc_f} = w_diff;
        w_sc_v = (!w_a_msb && w_b_msb && w_diff[WIDTH-1]) ||
                 (w_a_msb && !w_b_msb && !w_diff[WIDTH-1]);
      end
      c_fs_and: w_sc_f = bus.A & bus.B;
      c_fs_or:  w_sc_f = bus.A | bus.B;
      c_fs_xor: w_sc_f = bus.A ^ bus.B;
      c_fs_not: w_sc_f = ~bus.A;
      c_fs_lsl: begin
        w_sc_f = bus.A << bus.SH;
        w_sc_c = bus.A[WIDTH-1];
      end
      c_fs_lsr: begin
        w_sc_f = bus.A >> bus.SH;
        w_sc_c = bus.A[0];
      end
      c_fs_asr: begin
        w_sc_f = $signed(bus.A) >>> bus.SH;
        w_sc_c = bus.A[0];
      end
      c_fs_ror: begin
        // A shift by WIDTH yields zero, so SH=0 leaves A untouched.
        w_sc_f = (bus.A >> bus.SH) | (bus.A << (WIDTH - int'(bus.SH)));
        w_sc_c = w_sc_f[WIDTH-1];
      end
      default: w_sc_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [4:0]     c_fs_mul   = 5'b11000;
  localparam logic [SHW-1:0] c_cnt_last = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, acc_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [SHW-1:0]       cnt_q;
  logic [2*WIDTH-1:0]   w_acc_nx;
  logic                 w_is_mul;
  logic                 w_mul_start;

  assign w_is_mul = (bus.FS == c_fs_mul);
  assign w_acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    w_in_ready  = 1'b0;
    w_busy      = 1'b0;
    w_load      = 1'b0;
    w_mul_start = 1'b0;
    w_res_f     = w_sc_f;
    w_res_c     = w_sc_c;
    w_res_v     = w_sc_v;
    w_res_ill   = w_sc_ill;
    case (state_q)
      S_IDLE: begin
        w_in_ready = w_out_free && !rst;
        if (w_in_ready && bus.in_valid) begin
          if (w_is_mul) begin
            w_mul_start = 1'b1;
            state_d     = S_MUL;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      S_MUL: begin
        w_busy = 1'b1;
        if (cnt_q == c_cnt_last) begin
          w_res_f   = w_acc_nx[WIDTH-1:0];
          w_res_c   = |w_acc_nx[2*WIDTH-1:WIDTH];
          w_res_v   = 1'b0;
          w_res_ill = 1'b0;
          if (w_out_free) begin
            w_load  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_res_f   = acc_q[WIDTH-1:0];
        w_res_c   = |acc_q[2*WIDTH-1:WIDTH];
        w_res_v   = 1'b0;
        w_res_ill = 1'b0;
        if (w_out_free) begin
          w_load  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shift-add, one multiplier bit per cycle, LSB first; acc_q keeps the product for DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (w_mul_start) begin
      mcand_q  <= {{WIDTH{1'b0}}, bus.A};
      mplier_q <= bus.B;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == S_MUL) begin
      acc_q    <= w_acc_nx;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end
`else
  assign w_in_ready = w_out_free && !rst;
  assign w_load     = w_in_ready && bus.in_valid;
  assign w_busy     = 1'b0;
  assign w_res_f    = w_sc_f;
  assign w_res_c    = w_sc_c;
  assign w_res_v    = w_sc_v;
  assign w_res_ill  = w_sc_ill;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      f_q         <= '0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      out_valid_q <= w_load || (out_valid_q && !bus.out_ready);
      if (w_load) begin
        f_q   <= w_res_f;
        z_q   <= (w_res_f == '0);
        n_q   <= w_res_f[WIDTH-1];
        v_q   <= w_res_v;
        c_q   <= w_res_c;
        ill_q <= w_res_ill;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.out_valid = out_valid_q;
  assign bus.F         = f_q;
  assign bus.Z         = z_q;
  assign bus.V         = v_q;
  assign bus.N         = n_q;
  assign bus.C         = c_q;
  assign bus.ILL       = ill_q;
endmodule
`default_nettype wire
